wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/wb_arbiter.sv | 88 ++++++++
 tb/tb_wb_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared writeback constants: register address width, register count,
// requester index assignments and a one-hot decode helper.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MUL = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // One-hot decode of a register address; x0 never produces a bit.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t a);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    v[0] = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from valid, search starts one past the
// last granted index, pointer loads the granted index on every grant.
module rr_arbiter #(
  parameter int NREQ  = 3,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  valid,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] gidx,
  output logic             gnt_any
);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] cand;

  // Walk candidates ptr+1 .. ptr+NREQ (wrapping); first valid one wins.
  // Grants are suppressed while reset is held.
  always_comb begin
    grant   = '0;
    gidx    = '0;
    gnt_any = 1'b0;
    cand    = ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == PTR_W'(NREQ-1)) ? '0 : cand + PTR_W'(1);
      if (rst_n && !gnt_any && valid[cand]) begin
        grant[cand] = 1'b1;
        gidx        = cand;
        gnt_any     = 1'b1;
      end
    end
  end

  // Pointer remembers the last winner; reset value gives req0 first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= PTR_W'(NREQ-1);
    else if (gnt_any) ptr <= gidx;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one of NREQ writeback requesters per cycle,
// registers the winner onto the register-file write port, and optionally
// tracks outstanding writes in a busy scoreboard.
// Optional feature macro: WB_SCOREBOARD_EN (busy scoreboard + query ports).
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*5-1:0]      req_rd,
  input  logic [NREQ*XLEN-1:0]   req_data,
  output logic                   rf_we,
  output logic [4:0]             rf_waddr,
  output logic [XLEN-1:0]        rf_wdata,
  input  logic                   iss_valid,
  input  logic [4:0]             iss_rd,
  input  logic [4:0]             qry_addr0,
  input  logic [4:0]             qry_addr1,
  output logic                   qry_busy0,
  output logic                   qry_busy1
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0][REG_ADDR_W-1:0] rd_arr;
  logic [NREQ-1:0][XLEN-1:0]       data_arr;
  logic [PTR_W-1:0]                gidx;
  logic                            gnt_any;

  assign rd_arr   = req_rd;
  assign data_arr = req_data;

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .grant   (req_ready),
    .gidx    (gidx),
    .gnt_any (gnt_any)
  );

  // Output register: capture the winner; writes to x0 are consumed silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (gnt_any) begin
      rf_we    <= (rd_arr[gidx] != '0);
      rf_waddr <= rd_arr[gidx];
      rf_wdata <= data_arr[gidx];
    end else begin
      rf_we    <= 1'b0;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_set;
  logic [NUM_REGS-1:0] busy_clr;

  // Set on issue, clear on commit; set wins when both hit the same register.
  always_comb begin
    busy_set = iss_valid ? reg_onehot(iss_rd)   : '0;
    busy_clr = rf_we     ? reg_onehot(rf_waddr) : '0;
  end

  // Busy vector; bit 0 can never be set since reg_onehot masks x0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= (busy & ~busy_clr) | busy_set;
  end

  assign qry_busy0 = busy[qry_addr0];
  assign qry_busy1 = busy[qry_addr1];
`else
  logic unused_sb;
  assign unused_sb = ^{iss_valid, iss_rd, qry_addr0, qry_addr1};
  assign qry_busy0 = 1'b0;
  assign qry_busy1 = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized
// run, all checked against a behavioural model of arbitration and scoreboard.
module tb_wb_arbiter;

  localparam int XLEN = 32;
  localparam int NREQ = 3;
`ifdef WB_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*5-1:0]    req_rd = '0;
  logic [NREQ*XLEN-1:0] req_data = '0;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 iss_valid = 1'b0;
  logic [4:0]           iss_rd = '0;
  logic [4:0]           qry_addr0 = '0;
  logic [4:0]           qry_addr1 = '0;
  logic                 qry_busy0;
  logic                 qry_busy1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          m_ptr;
  bit          m_we;
  bit [4:0]    m_waddr;
  bit [31:0]   m_wdata;
  bit [31:0]   m_busy;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .qry_addr0(qry_addr0), .qry_addr1(qry_addr1),
    .qry_busy0(qry_busy0), .qry_busy1(qry_busy1)
  );

  // Winner: first valid index scanning forward from one past the last winner.
  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    int g;
    r = '0;
    g = pick(req_valid, m_ptr);
    if (rst_n && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic bit exp_busy(input logic [4:0] a);
    return SB_EN && (a != 0) && m_busy[a];
  endfunction

  task automatic model_reset();
    m_ptr = NREQ - 1; m_we = 0; m_waddr = 0; m_wdata = 0; m_busy = 0;
  endtask

  // Advance the model by one rising edge using the inputs presented now.
  task automatic model_edge();
    bit [31:0] nb;
    bit [4:0]  rd;
    int g;
    nb = m_busy;
    if (SB_EN) begin
      if (m_we) nb[m_waddr] = 1'b0;
      if (iss_valid && iss_rd != 0) nb[iss_rd] = 1'b1;
    end
    g = pick(req_valid, m_ptr);
    if (g >= 0) begin
      rd      = req_rd[g*5 +: 5];
      m_ptr   = g;
      m_we    = (rd != 0);
      m_waddr = rd;
      m_wdata = req_data[g*XLEN +: XLEN];
    end else begin
      m_we = 1'b0;
    end
    m_busy = nb;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [4:0] rd, input logic [31:0] d);
    req_valid[i]         = v;
    req_rd[i*5 +: 5]     = rd;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic pulse_reset();
    #3 rst_n = 1'b0;
    model_reset();
    req_valid = '0; iss_valid = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    #2;
    n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== '0) begin n_bad++; $display("FAIL reset_rf: got we=%b a=%0d d=%h want 0", rf_we, rf_waddr, rf_wdata); end
    req_valid = '0;
    model_reset();
    rst_n = 1'b1;
    step();
    // Mid-write reset: req1 writes x5 while x5 is issued busy.
    qry_addr0 = 5; iss_valid = 1'b1; iss_rd = 5;
    set_req(1, 1'b1, 5, 32'h1234_5678);
    step();
    req_valid = '0; iss_valid = 1'b0;
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5) begin n_bad++; $display("FAIL reset_prewrite: got we=%b a=%0d want we=1 a=5", rf_we, rf_waddr); end
    n_cmp++; if (qry_busy0 !== SB_EN) begin n_bad++; $display("FAIL reset_prebusy: got %b want %b", qry_busy0, SB_EN); end
    #2 rst_n = 1'b0;
    req_valid = '1;
    #1;
    n_cmp++; if (rf_we !== 1'b0 || rf_waddr !== 0 || rf_wdata !== 0) begin n_bad++; $display("FAIL reset_async: got we=%b a=%0d d=%h want 0", rf_we, rf_waddr, rf_wdata); end
    n_cmp++; if (qry_busy0 !== 1'b0 || qry_busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b%b want 00", qry_busy0, qry_busy1); end
    n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL reset_ready_mid: got %b want 000", req_ready); end
    model_reset();
    req_valid = '0;
    #1 rst_n = 1'b1;
    step();
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_nocommit: got we=%b want 0", rf_we); end
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 3, 32'hDEAD_BEEF);
    #3;
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL single_ready: got %b want 001", req_ready); end
    step();
    req_valid = '0;
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hDEAD_BEEF)
      begin n_bad++; $display("FAIL single_write: got we=%b a=%0d d=%h want we=1 a=3 d=deadbeef", rf_we, rf_waddr, rf_wdata); end
    step();
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL single_idle: got we=%b want 0", rf_we); end
  endtask

  task automatic test_contention();
    int order [3] = '{0, 1, 2};
    pulse_reset();
    step();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(10 + i), $urandom);
    for (int c = 0; c < 3; c++) begin
      #3;
      n_cmp++; if (req_ready !== exp_ready() || req_ready !== 3'(1 << order[c]))
        begin n_bad++; $display("FAIL contention_grant%0d: got %b want %b", c, req_ready, 3'(1 << order[c])); end
      step();
      req_valid[order[c]] = 1'b0;
      n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'(10 + order[c]) || rf_wdata !== m_wdata)
        begin n_bad++; $display("FAIL contention_write%0d: got we=%b a=%0d d=%h want a=%0d d=%h", c, rf_we, rf_waddr, rf_wdata, 10 + order[c], m_wdata); end
    end
    step();
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL contention_idle: got we=%b want 0", rf_we); end
  endtask

  task automatic test_fairness();
    int order [6] = '{0, 1, 2, 0, 1, 2};
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(20 + i), 32'(i));
    for (int c = 0; c < 6; c++) begin
      #3;
      n_cmp++; if (req_ready !== 3'(1 << order[c]))
        begin n_bad++; $display("FAIL fairness_grant%0d: got %b want %b", c, req_ready, 3'(1 << order[c])); end
      step();
      n_cmp++; if (rf_waddr !== 5'(20 + order[c])) begin n_bad++; $display("FAIL fairness_addr%0d: got %0d want %0d", c, rf_waddr, 20 + order[c]); end
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_rd0();
    set_req(1, 1'b1, 0, 32'hCAFE_F00D);
    #3;
    n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL rd0_ready: got %b want 010", req_ready); end
    step();
    n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL rd0_we: got %b want 0", rf_we); end
    // Pointer now 1, so with all valid req2 has priority.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(1 + i), 32'(i));
    #3;
    n_cmp++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL rd0_ptr: got %b want 100", req_ready); end
    step();
    req_valid = '0;
    step();
  endtask

  task automatic test_scoreboard();
    qry_addr0 = 7; qry_addr1 = 0;
    iss_valid = 1'b1; iss_rd = 7;
    step();
    iss_rd = 0;
    #3;
    n_cmp++; if (qry_busy0 !== SB_EN) begin n_bad++; $display("FAIL sb_issue: got %b want %b", qry_busy0, SB_EN); end
    n_cmp++; if (qry_busy1 !== 1'b0) begin n_bad++; $display("FAIL sb_x0: got %b want 0", qry_busy1); end
    iss_valid = 1'b0;
    set_req(0, 1'b1, 7, 32'h0000_0077);
    step();
    req_valid = '0;
    iss_valid = 1'b1; iss_rd = 7;
    step();
    iss_valid = 1'b0;
    n_cmp++; if (qry_busy0 !== SB_EN) begin n_bad++; $display("FAIL sb_setwins: got %b want %b", qry_busy0, SB_EN); end
    set_req(0, 1'b1, 7, 32'h0000_0078);
    step();
    req_valid = '0;
    step();
    n_cmp++; if (qry_busy0 !== 1'b0) begin n_bad++; $display("FAIL sb_commit: got %b want 0", qry_busy0); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req_valid = 3'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_rd[i*5 +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        req_data[i*XLEN +: XLEN] = $urandom;
      end
      iss_valid = 1'($urandom);
      iss_rd    = 5'($urandom);
      qry_addr0 = 5'($urandom);
      qry_addr1 = 5'($urandom_range(0, 3));
      #3;
      n_cmp++; if (req_ready !== exp_ready()) begin n_bad++; $display("FAIL rand_ready@%0d: got %b want %b", c, req_ready, exp_ready()); end
      n_cmp++; if (qry_busy0 !== exp_busy(qry_addr0) || qry_busy1 !== exp_busy(qry_addr1))
        begin n_bad++; $display("FAIL rand_busy@%0d: got %b%b want %b%b", c, qry_busy0, qry_busy1, exp_busy(qry_addr0), exp_busy(qry_addr1)); end
      step();
      n_cmp++; if (rf_we !== m_we || (m_we && (rf_waddr !== m_waddr || rf_wdata !== m_wdata)))
        begin n_bad++; $display("FAIL rand_rf@%0d: got we=%b a=%0d d=%h want we=%b a=%0d d=%h", c, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata); end
    end
    req_valid = '0; iss_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_rd0();
    test_scoreboard();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
